// File: rtl/heap_ops.sv
// Shared bbq heap op encodings, default heap geometry and feeder FSM states.
package heap_ops;

  localparam int DEF_HEAP_ENTRY_DWIDTH    = 17;
  localparam int DEF_HEAP_PRIORITY_AWIDTH = 15;
  localparam int DEF_HEAP_MAX_NUM_ENTRIES = 131071;

  typedef enum logic [0:0] {
    HEAP_OP_ENQUE     = 1'b0,
    HEAP_OP_DEQUE_MIN = 1'b1
  } heap_op_t;

  typedef enum logic [0:0] {
    FEED_INIT = 1'b0,
    FEED_RUN  = 1'b1
  } feed_state_t;

endpackage

// File: rtl/bbq_req_fifo.sv
// Generic registered synchronous FIFO; head is read straight from storage, so a
// word written at one edge is poppable at the next edge at the earliest.
module bbq_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == CNT_ZERO);
  assign head      = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array and pointers; every entry clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Fill level; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bbq_req_feeder.sv
// Request front-end for the bbq heap: buffers client ops, waits for heap init and
// issues admitted ops on a registered valid/ready stage while tracking occupancy.
module bbq_req_feeder
  import heap_ops::*;
#(
  parameter int HEAP_ENTRY_DWIDTH    = DEF_HEAP_ENTRY_DWIDTH,
  parameter int HEAP_PRIORITY_AWIDTH = DEF_HEAP_PRIORITY_AWIDTH,
  parameter int HEAP_MAX_NUM_ENTRIES = DEF_HEAP_MAX_NUM_ENTRIES,
  parameter int FIFO_DEPTH           = 16,
  parameter int OCC_WIDTH            = $clog2(HEAP_MAX_NUM_ENTRIES + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  heap_op_t                        req_op_type,
  input  logic [HEAP_ENTRY_DWIDTH-1:0]    req_data,
  input  logic [HEAP_PRIORITY_AWIDTH-1:0] req_priority,
  input  logic                            heap_ready,
  output logic                            heap_in_valid,
  output heap_op_t                        heap_in_op_type,
  output logic [HEAP_ENTRY_DWIDTH-1:0]    heap_in_he_data,
  output logic [HEAP_PRIORITY_AWIDTH-1:0] heap_in_he_priority,
  output logic                            init_done,
  output logic [OCC_WIDTH-1:0]            occupancy,
  output logic                            drop_enque,
  output logic                            drop_deque
);
  typedef struct packed {
    heap_op_t                        op_type;
    logic [HEAP_ENTRY_DWIDTH-1:0]    data;
    logic [HEAP_PRIORITY_AWIDTH-1:0] prio;
  } req_word_t;

  localparam int REQ_WIDTH = $bits(req_word_t);
  localparam logic [OCC_WIDTH-1:0] OCC_FULL = OCC_WIDTH'(HEAP_MAX_NUM_ENTRIES);
  localparam logic [OCC_WIDTH-1:0] OCC_ZERO = {OCC_WIDTH{1'b0}};
  localparam logic [OCC_WIDTH-1:0] OCC_ONE  = OCC_WIDTH'(1'b1);

  feed_state_t                     state_r;
  feed_state_t                     state_next_s;
  logic                            run_s;
  logic                            init_done_r;
  req_word_t                       push_word_s;
  req_word_t                       head_word_s;
  logic                            fifo_full_s;
  logic                            fifo_empty_s;
  logic                            push_s;
  logic                            pop_s;
  logic                            load_s;
  logic                            drop_enq_s;
  logic                            drop_deq_s;
  logic [OCC_WIDTH-1:0]            occ_next_s;
  logic [HEAP_ENTRY_DWIDTH-1:0]    load_data_s;
  logic [HEAP_PRIORITY_AWIDTH-1:0] load_prio_s;
  logic                            slot_valid_r;
  heap_op_t                        slot_op_r;
  logic [HEAP_ENTRY_DWIDTH-1:0]    slot_data_r;
  logic [HEAP_PRIORITY_AWIDTH-1:0] slot_prio_r;
  logic [OCC_WIDTH-1:0]            occ_r;
  logic                            drop_enq_r;
  logic                            drop_deq_r;

  assign push_word_s = '{op_type: req_op_type, data: req_data, prio: req_priority};
  assign req_ready   = run_s && !fifo_full_s;
  assign push_s      = req_valid && req_ready;
  // The slot can take a new op when empty or when its current op is being accepted.
  assign pop_s       = (!slot_valid_r || heap_ready) && !fifo_empty_s;

  bbq_req_fifo #(
    .WIDTH (REQ_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_word_s),
    .pop       (pop_s),
    .head      (head_word_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // State register and sticky init flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= FEED_INIT;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      init_done_r <= (state_next_s == FEED_RUN);
    end
  end

  // Next state: leave INIT on the first cycle the heap reports ready.
  always_comb begin
    state_next_s = state_r;
    run_s        = 1'b0;
    case (state_r)
      FEED_INIT: begin
        if (heap_ready) begin
          state_next_s = FEED_RUN;
        end else begin
          state_next_s = FEED_INIT;
        end
      end
      FEED_RUN: begin
        run_s        = 1'b1;
        state_next_s = FEED_RUN;
      end
      default: begin
        state_next_s = FEED_INIT;
      end
    endcase
  end

  // Admission of the popped head against the committed occupancy.
  always_comb begin
    load_s      = 1'b0;
    drop_enq_s  = 1'b0;
    drop_deq_s  = 1'b0;
    occ_next_s  = occ_r;
    load_data_s = {HEAP_ENTRY_DWIDTH{1'b0}};
    load_prio_s = {HEAP_PRIORITY_AWIDTH{1'b0}};
    if (pop_s) begin
      case (head_word_s.op_type)
        HEAP_OP_ENQUE: begin
          if (occ_r == OCC_FULL) begin
            drop_enq_s = 1'b1;
          end else begin
            load_s      = 1'b1;
            occ_next_s  = occ_r + OCC_ONE;
            load_data_s = head_word_s.data;
            load_prio_s = head_word_s.prio;
          end
        end
        HEAP_OP_DEQUE_MIN: begin
          if (occ_r == OCC_ZERO) begin
            drop_deq_s = 1'b1;
          end else begin
            load_s     = 1'b1;
            occ_next_s = occ_r - OCC_ONE;
          end
        end
        default: begin
          load_s = 1'b0;
        end
      endcase
    end else begin
      load_s = 1'b0;
    end
  end

  // Output slot: refill from an admitted op, otherwise empty it on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_r <= 1'b0;
      slot_op_r    <= HEAP_OP_ENQUE;
      slot_data_r  <= {HEAP_ENTRY_DWIDTH{1'b0}};
      slot_prio_r  <= {HEAP_PRIORITY_AWIDTH{1'b0}};
    end else if (load_s) begin
      slot_valid_r <= 1'b1;
      slot_op_r    <= head_word_s.op_type;
      slot_data_r  <= load_data_s;
      slot_prio_r  <= load_prio_s;
    end else if (heap_ready) begin
      slot_valid_r <= 1'b0;
    end
  end

  // Occupancy and drop pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r      <= OCC_ZERO;
      drop_enq_r <= 1'b0;
      drop_deq_r <= 1'b0;
    end else begin
      occ_r      <= occ_next_s;
      drop_enq_r <= drop_enq_s;
      drop_deq_r <= drop_deq_s;
    end
  end

  assign heap_in_valid       = slot_valid_r;
  assign heap_in_op_type     = slot_op_r;
  assign heap_in_he_data     = slot_data_r;
  assign heap_in_he_priority = slot_prio_r;
  assign init_done           = init_done_r;
  assign occupancy           = occ_r;
  assign drop_enque          = drop_enq_r;
  assign drop_deque          = drop_deq_r;

endmodule

// File: tb/tb_bbq_req_feeder.sv
// Bench for bbq_req_feeder: queue-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_bbq_req_feeder;
  import heap_ops::*;

  localparam int DW    = 17;
  localparam int PW    = 15;
  localparam int MAXE  = 20;
  localparam int DEPTH = 16;
  localparam int OW    = $clog2(MAXE + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  heap_op_t      req_op_type = HEAP_OP_ENQUE;
  logic [DW-1:0] req_data = '0;
  logic [PW-1:0] req_priority = '0;
  logic          heap_ready = 1'b0;
  logic          heap_in_valid;
  heap_op_t      heap_in_op_type;
  logic [DW-1:0] heap_in_he_data;
  logic [PW-1:0] heap_in_he_priority;
  logic          init_done;
  logic [OW-1:0] occupancy;
  logic          drop_enque;
  logic          drop_deque;

  int checks = 0;
  int failures = 0;

  bbq_req_feeder #(
    .HEAP_ENTRY_DWIDTH    (DW),
    .HEAP_PRIORITY_AWIDTH (PW),
    .HEAP_MAX_NUM_ENTRIES (MAXE),
    .FIFO_DEPTH           (DEPTH)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_op_type         (req_op_type),
    .req_data            (req_data),
    .req_priority        (req_priority),
    .heap_ready          (heap_ready),
    .heap_in_valid       (heap_in_valid),
    .heap_in_op_type     (heap_in_op_type),
    .heap_in_he_data     (heap_in_he_data),
    .heap_in_he_priority (heap_in_he_priority),
    .init_done           (init_done),
    .occupancy           (occupancy),
    .drop_enque          (drop_enque),
    .drop_deque          (drop_deque)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    heap_op_t      op;
    logic [DW-1:0] d;
    logic [PW-1:0] p;
  } mreq_t;

  mreq_t         m_fifo[$];
  bit            m_run = 1'b0;
  bit            m_init = 1'b0;
  bit            m_sv = 1'b0;
  heap_op_t      m_sop = HEAP_OP_ENQUE;
  logic [DW-1:0] m_sd = '0;
  logic [PW-1:0] m_sp = '0;
  int            m_occ = 0;
  bit            m_de = 1'b0;
  bit            m_dd = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_fifo.delete();
        m_run = 1'b0; m_init = 1'b0; m_sv = 1'b0; m_sop = HEAP_OP_ENQUE;
        m_sd = '0; m_sp = '0; m_occ = 0; m_de = 1'b0; m_dd = 1'b0;
      end else begin
        bit    can_take;
        bit    free;
        mreq_t h;
        mreq_t n;
        can_take = m_run && (m_fifo.size() < DEPTH);
        free = !m_sv || heap_ready;
        m_de = 1'b0;
        m_dd = 1'b0;
        if (m_sv && heap_ready) m_sv = 1'b0;
        if (free && m_fifo.size() > 0) begin
          h = m_fifo.pop_front();
          if (h.op == HEAP_OP_ENQUE && m_occ == MAXE) m_de = 1'b1;
          else if (h.op == HEAP_OP_DEQUE_MIN && m_occ == 0) m_dd = 1'b1;
          else begin
            m_sv = 1'b1;
            m_sop = h.op;
            m_sd = (h.op == HEAP_OP_ENQUE) ? h.d : '0;
            m_sp = (h.op == HEAP_OP_ENQUE) ? h.p : '0;
            m_occ = m_occ + ((h.op == HEAP_OP_ENQUE) ? 1 : -1);
          end
        end
        if (can_take && req_valid) begin
          n.op = req_op_type; n.d = req_data; n.p = req_priority;
          m_fifo.push_back(n);
        end
        if (!m_run && heap_ready) begin
          m_run = 1'b1;
          m_init = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("req_ready", req_ready, m_run && (m_fifo.size() < DEPTH));
      check("heap_in_valid", heap_in_valid, m_sv);
      if (m_sv) begin
        check("heap_in_op_type", heap_in_op_type, m_sop);
        check("heap_in_he_data", heap_in_he_data, m_sd);
        check("heap_in_he_priority", heap_in_he_priority, m_sp);
      end
      check("init_done", init_done, m_init);
      check("occupancy", occupancy, m_occ);
      check("drop_enque", drop_enque, m_de);
      check("drop_deque", drop_deque, m_dd);
    end
  end

  // Handshake log and drop-pulse counters taken from the DUT outputs.
  logic [DW-1:0] log_d[$];
  int            log_cyc[$];
  int            cyc = 0;
  int            n_de = 0;
  int            n_dd = 0;
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n && heap_in_valid && heap_ready) begin
        log_d.push_back(heap_in_he_data);
        log_cyc.push_back(cyc);
      end
      if (drop_enque) n_de++;
      if (drop_deque) n_dd++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input heap_op_t op, input logic [DW-1:0] d, input logic [PW-1:0] p);
    req_valid = v; req_op_type = op; req_data = d; req_priority = p;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b0);
    check({tag, "_valid"}, heap_in_valid, 1'b0);
    check({tag, "_op"}, heap_in_op_type, HEAP_OP_ENQUE);
    check({tag, "_data"}, heap_in_he_data, 17'h0);
    check({tag, "_prio"}, heap_in_he_priority, 15'h0);
    check({tag, "_init_done"}, init_done, 1'b0);
    check({tag, "_occ"}, occupancy, 5'd0);
    check({tag, "_drops"}, {drop_enque, drop_deque}, 2'b00);
  endtask

  initial begin
    int base;
    int acc;
    int dd0;
    int de0;
    logic a;

    // Reset and init handshake; requests offered before init must not be taken.
    step(); step();
    check_reset_values("reset");
    rst_n = 1'b1;
    drive(1'b1, HEAP_OP_ENQUE, 17'h5, 15'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("init_req_ready", req_ready, 1'b0);
    end
    heap_ready = 1'b1;
    drive(1'b0, HEAP_OP_ENQUE, 17'h0, 15'h0);
    step();
    check("init_done_set", init_done, 1'b1);
    check("ready_after_init", req_ready, 1'b1);
    step(); step();
    check("no_stale_valid", heap_in_valid, 1'b0);
    check("no_stale_occ", occupancy, 5'd0);

    // Single enqueue: visible one edge after acceptance.
    drive(1'b1, HEAP_OP_ENQUE, 17'h1A, 15'd7);
    step();
    drive(1'b0, HEAP_OP_ENQUE, 17'h0, 15'h0);
    step();
    check("enq_valid", heap_in_valid, 1'b1);
    check("enq_data", heap_in_he_data, 17'h1A);
    check("enq_prio", heap_in_he_priority, 15'd7);
    check("enq_occ", occupancy, 5'd1);
    step();
    check("enq_valid_clears", heap_in_valid, 1'b0);

    // Two dequeues: first admitted with zeroed payload, second hits empty.
    dd0 = n_dd;
    drive(1'b1, HEAP_OP_DEQUE_MIN, 17'h155, 15'h33);
    step();
    step();
    drive(1'b0, HEAP_OP_ENQUE, 17'h0, 15'h0);
    check("deq_valid", heap_in_valid, 1'b1);
    check("deq_op", heap_in_op_type, HEAP_OP_DEQUE_MIN);
    check("deq_data_zero", heap_in_he_data, 17'h0);
    check("deq_prio_zero", heap_in_he_priority, 15'h0);
    check("deq_occ", occupancy, 5'd0);
    step();
    check("deq_drop_pulse", drop_deque, 1'b1);
    check("deq_drop_valid", heap_in_valid, 1'b0);
    step();
    check("deq_drop_once", drop_deque, 1'b0);
    check("deq_drop_count", n_dd - dd0, 1);
    check("deq_occ_stays", occupancy, 5'd0);

    // Back-pressure: 16 FIFO entries plus the slot, then an in-order burst.
    heap_ready = 1'b0;
    base = log_d.size();
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, HEAP_OP_ENQUE, DW'(100 + acc), PW'(acc));
      a = req_ready;
      step();
      if (a) acc++;
    end
    drive(1'b0, HEAP_OP_ENQUE, 17'h0, 15'h0);
    check("bp_accepted", acc, 17);
    check("bp_req_ready", req_ready, 1'b0);
    check("bp_slot_data", heap_in_he_data, 17'd100);
    check("bp_occ", occupancy, 5'd1);
    heap_ready = 1'b1;
    for (int k = 0; k < 40 && (log_d.size() - base) < 17; k++) step();
    step();
    check("bp_issued", log_d.size() - base, 17);
    if (log_d.size() - base >= 17) begin
      for (int i = 0; i < 17; i++) check("bp_order", log_d[base + i], DW'(100 + i));
      check("bp_back_to_back", log_cyc[base + 16] - log_cyc[base], 16);
    end
    check("bp_occ_after", occupancy, 5'd17);

    // Reset mid-stream with one op in the slot and five queued.
    heap_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, HEAP_OP_ENQUE, DW'(200 + i), PW'(i));
      step();
    end
    drive(1'b0, HEAP_OP_ENQUE, 17'h0, 15'h0);
    check("pre_rst_valid", heap_in_valid, 1'b1);
    check("pre_rst_occ", occupancy, 5'd18);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    step();
    rst_n = 1'b1;
    heap_ready = 1'b1;
    base = log_d.size();
    for (int i = 0; i < 6; i++) step();
    check("post_rst_issued", log_d.size() - base, 0);
    check("post_rst_valid", heap_in_valid, 1'b0);
    check("post_rst_occ", occupancy, 5'd0);
    check("post_rst_init", init_done, 1'b1);

    // Overflow: capacity 20, the 21st enqueue is dropped.
    base = log_d.size();
    de0 = n_de;
    for (int i = 0; i < 21; i++) begin
      drive(1'b1, HEAP_OP_ENQUE, DW'(300 + i), PW'(i));
      step();
    end
    drive(1'b0, HEAP_OP_ENQUE, 17'h0, 15'h0);
    for (int i = 0; i < 4; i++) step();
    check("ovf_issued", log_d.size() - base, 20);
    check("ovf_drop_count", n_de - de0, 1);
    check("ovf_occ", occupancy, 5'd20);
    if (log_d.size() > 0) check("ovf_last_data", log_d[log_d.size() - 1], DW'(319));

    // Dequeue at full capacity is admitted.
    drive(1'b1, HEAP_OP_DEQUE_MIN, 17'h0, 15'h0);
    step();
    drive(1'b0, HEAP_OP_ENQUE, 17'h0, 15'h0);
    for (int i = 0; i < 3; i++) step();
    check("full_deq_occ", occupancy, 5'd19);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
